// File: rtl/counter_sample_fifo.sv
// Snapshots the counter value on a sample strobe into a small FIFO drained by a valid/ready consumer.
// Optional SAMPLE_WRAP_TAG_EN adds a per-entry wrap tag and the o_out_wrap port.
module counter_sample_fifo #(
    parameter int Size  = 5,
    parameter int Depth = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [Size-1:0]          i_count,
    input  logic                     i_sample,
    output logic [Size-1:0]          o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(Depth):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clear_ovf
`ifdef SAMPLE_WRAP_TAG_EN
    ,
    output logic                     o_out_wrap
`endif
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [Size-1:0] r_mem [Depth];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic [Size-1:0] r_out_data;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [AW-1:0]   w_rptr_nxt;
    logic [LW-1:0]   w_level_nxt;
    logic            w_head_load;
    logic            w_head_is_new;
    logic [Size-1:0] w_head_data;

    // Handshake: the head transfers on an edge where o_out_valid and i_out_ready are both high;
    // o_out_valid depends only on stored state, never on i_out_ready.
    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == LW'(Depth));
    assign w_pop         = ~w_empty & i_out_ready;
    assign w_push        = i_sample & (~w_full | w_pop);
    assign w_drop        = i_sample & ~w_push;
    assign w_rptr_nxt    = r_rptr + AW'(w_pop);
    assign w_level_nxt   = r_level + LW'(w_push) - LW'(w_pop);

    // The head register reloads only when the head entry changes and something remains;
    // if the new head is the slot being written this edge, take it straight from i_count.
    assign w_head_load   = (w_level_nxt != '0) & (w_pop | w_empty);
    assign w_head_is_new = w_push & (r_wptr == w_rptr_nxt);
    assign w_head_data   = w_head_is_new ? i_count : r_mem[w_rptr_nxt];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_count;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            // A drop on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_head_load) begin
                r_out_data <= w_head_data;
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = ~w_empty;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;

`ifdef SAMPLE_WRAP_TAG_EN
    logic            r_tag_mem [Depth];
    logic [Size-1:0] r_prev_count;
    logic            r_wrap_pending;
    logic            r_out_wrap;
    logic            w_wrap_evt;
    logic            w_tag_in;

    assign w_wrap_evt = (i_count < r_prev_count);
    assign w_tag_in   = r_wrap_pending | w_wrap_evt;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tag_mem[r_wptr] <= w_tag_in;
        end
    end

    // A pending wrap is consumed only by an accepted push; dropped samples keep it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_count   <= '0;
            r_wrap_pending <= 1'b0;
            r_out_wrap     <= 1'b0;
        end else begin
            r_prev_count <= i_count;
            if (w_push) begin
                r_wrap_pending <= 1'b0;
            end else if (w_wrap_evt) begin
                r_wrap_pending <= 1'b1;
            end
            if (w_level_nxt == '0) begin
                r_out_wrap <= 1'b0;
            end else if (w_head_load) begin
                r_out_wrap <= w_head_is_new ? w_tag_in : r_tag_mem[w_rptr_nxt];
            end
        end
    end

    assign o_out_wrap = r_out_wrap;
`endif

endmodule

// File: tb/tb_counter_sample_fifo.sv
// Bench for counter_sample_fifo: queue-based reference model checked every cycle plus directed literal checks.
// Wrap-tag checks are active when SAMPLE_WRAP_TAG_EN is defined.
module tb_counter_sample_fifo;

    localparam int SIZE  = 5;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SIZE-1:0] count = '0;
    logic            sample = 1'b0;
    logic            out_ready = 1'b0;
    logic            clear_ovf = 1'b0;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic [LW-1:0]   level;
    logic            overflow;
`ifdef SAMPLE_WRAP_TAG_EN
    logic            out_wrap;
`endif

    counter_sample_fifo #(.Size(SIZE), .Depth(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_count     (count),
        .i_sample    (sample),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_level     (level),
        .o_overflow  (overflow),
        .i_clear_ovf (clear_ovf)
`ifdef SAMPLE_WRAP_TAG_EN
        ,
        .o_out_wrap  (out_wrap)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // reference model: a queue of samples, a sticky flag and the last head value
    logic [SIZE-1:0] exp_q[$];
    logic            tag_q[$];
    logic            m_ovf;
    logic [SIZE-1:0] m_hold;
    logic [SIZE-1:0] m_prev;
    logic            m_pending;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            tag_q.delete();
            m_ovf     = 1'b0;
            m_hold    = '0;
            m_prev    = '0;
            m_pending = 1'b0;
        end else begin
            bit do_pop, do_push, wrap, tag;
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = sample && ((exp_q.size() < DEPTH) || do_pop);
            wrap    = (count < m_prev);
            tag     = m_pending | wrap;
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(tag_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back(count);
                tag_q.push_back(tag);
            end
            if (clear_ovf) m_ovf = 1'b0;
            if (sample && !do_push) m_ovf = 1'b1;
            if (do_push) m_pending = 1'b0;
            else if (wrap) m_pending = 1'b1;
            m_prev = count;
            if (exp_q.size() > 0) m_hold = exp_q[0];
        end
    end

    // every-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_valid", int'(out_valid), int'(exp_q.size() > 0));
            chk("cmp_level", int'(level), exp_q.size());
            chk("cmp_overflow", int'(overflow), int'(m_ovf));
            chk("cmp_data", int'(out_data), int'(m_hold));
`ifdef SAMPLE_WRAP_TAG_EN
            chk("cmp_wrap", int'(out_wrap), (exp_q.size() > 0) ? int'(tag_q[0]) : 0);
`endif
        end
    end

    // driver tasks: inputs change 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [SIZE-1:0] c, input logic r, input logic cl);
        sample    = s;
        count     = c;
        out_ready = r;
        clear_ovf = cl;
    endtask

    initial begin
        int exp_d4[4];
        int exp_d5[3];
        int exp_t5[3];
        exp_d4 = '{2, 3, 4, 9};
        exp_d5 = '{30, 1, 2};
        exp_t5 = '{0, 1, 0};

        // power-on reset
        tick();
        tick();
        chk("por_level", int'(level), 0);
        chk("por_valid", int'(out_valid), 0);
        chk("por_overflow", int'(overflow), 0);
        chk("por_data", int'(out_data), 0);
        rst_n = 1'b1;

        // single capture and pop
        drive(1, 7, 0, 0); tick();
        drive(0, 7, 0, 0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 7);
        chk("single_level", int'(level), 1);
        drive(0, 7, 1, 0); tick();
        drive(0, 7, 0, 0);
        chk("single_pop_valid", int'(out_valid), 0);
        chk("single_pop_level", int'(level), 0);
        chk("single_hold_data", int'(out_data), 7);

        // fill, overflow, drain, clear
        for (int i = 1; i <= 5; i++) begin
            drive(1, SIZE'(i), 0, 0); tick();
        end
        drive(0, 5, 0, 0);
        chk("fill_level", int'(level), 4);
        chk("fill_overflow", int'(overflow), 1);
        drive(0, 5, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", int'(out_data), k);
            tick();
        end
        drive(0, 5, 0, 0);
        chk("drain_empty", int'(out_valid), 0);
        chk("drain_ovf_sticky", int'(overflow), 1);
        drive(0, 5, 0, 1); tick();
        drive(0, 5, 0, 0);
        chk("clear_overflow", int'(overflow), 0);

        // full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) begin
            drive(1, SIZE'(i), 0, 0); tick();
        end
        drive(1, 9, 1, 0); tick();
        drive(0, 9, 0, 0);
        chk("fullpp_level", int'(level), 4);
        chk("fullpp_overflow", int'(overflow), 0);
        drive(0, 9, 1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("fullpp_drain", int'(out_data), exp_d4[k]);
            tick();
        end
        drive(0, 9, 1, 0); tick();
        drive(0, 9, 0, 0);
        chk("ready_while_empty", int'(level), 0);

        // drop and clear on the same edge: set wins
        for (int i = 1; i <= 4; i++) begin
            drive(1, SIZE'(i), 0, 0); tick();
        end
        drive(1, 5, 0, 1); tick();
        drive(0, 5, 0, 0);
        chk("drop_beats_clear", int'(overflow), 1);

        // reset mid-run with 3 entries held and overflow set
        drive(0, 5, 1, 0); tick();
        drive(0, 5, 0, 0);
        chk("pre_reset_level", int'(level), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_overflow", int'(overflow), 0);
        chk("async_rst_data", int'(out_data), 0);
`ifdef SAMPLE_WRAP_TAG_EN
        chk("async_rst_wrap", int'(out_wrap), 0);
`endif
        tick();
        rst_n = 1'b1;
        drive(0, 28, 0, 0); tick();

        // counter wrap
        drive(0, 29, 0, 0); tick();
        drive(1, 30, 0, 0); tick();
        drive(0, 31, 0, 0); tick();
        drive(0, 0, 0, 0);  tick();
        drive(1, 1, 0, 0);  tick();
        drive(1, 2, 0, 0);  tick();
        drive(0, 2, 0, 0);
        chk("wrap_level", int'(level), 3);
        drive(0, 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_data", int'(out_data), exp_d5[k]);
`ifdef SAMPLE_WRAP_TAG_EN
            chk("wrap_tag", int'(out_wrap), exp_t5[k]);
`endif
            tick();
        end
        drive(0, 2, 0, 0);
        chk("wrap_drained", int'(out_valid), 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
